// File: rtl/video_pkg.sv
// Shared types and constants for the video test-pattern / monitor path.
package video_pkg;

  typedef enum logic {WAIT_SOF, IN_FRAME} mon_state_t;

  localparam logic [23:0] GRN = 24'h00ff00;
  localparam logic [23:0] RED = 24'hff0000;
  localparam logic [23:0] BLU = 24'h0000ff;
  localparam logic [23:0] BLK = 24'h000000;

  localparam int SCRW = 1920;
  localparam int SCRH = 1080;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice: fully registered ready, one-cycle latency.
module axis_skid_buf #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] skid;

  // s_ready low means the skid entry holds a beat, which implies m_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      skid    <= '0;
      s_ready <= 1'b1;
    end else if (s_ready) begin
      if (!m_valid || m_ready) begin
        m_valid <= s_valid;
        if (s_valid) m_data <= s_data;
      end else if (s_valid) begin
        skid    <= s_data;
        s_ready <= 1'b0;
      end
    end else if (m_ready) begin
      m_data  <= skid;
      s_ready <= 1'b1;
    end
  end

endmodule

// File: rtl/video_axis_monitor.sv
// Inline AXI-Stream video checker: forwards pixels through a skid buffer and
// measures line width, frame height and frame count against expected geometry.
module video_axis_monitor
  import video_pkg::*;
#(
  parameter int DATAW = 24,
  parameter int CNTW  = 13,
  parameter int FCW   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DATAW-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic [DATAW-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  input  logic [CNTW-1:0]  exp_width,
  input  logic [CNTW-1:0]  exp_height,
  input  logic             clr_err,
  output logic [CNTW-1:0]  meas_width,
  output logic [CNTW-1:0]  meas_height,
  output logic [FCW-1:0]   frame_cnt,
  output logic             err_eol_early,
  output logic             err_eol_late,
  output logic             err_sof_pos,
  output logic             err_height,
  output logic             locked
);

  localparam logic [CNTW-1:0] ONES = '1;

  axis_skid_buf #(.W(DATAW+2)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  ({s_axis_tuser, s_axis_tlast, s_axis_tdata}),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  ({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  mon_state_t      state, state_nxt;
  logic            hs;
  logic [CNTW-1:0] px_cnt, ln_cnt;
  logic [CNTW-1:0] px_base, px_inc, ln_base, ln_inc;
  logic            close_ev, early_ev, late_ev, sof_pos_ev, height_ev, err_ev;
  logic            frame_err, one_clean;

  assign hs = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_SOF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (hs && s_axis_tuser) state_nxt = IN_FRAME;
  end

  // A tuser beat always starts a fresh line, so its position counts from zero.
  always_comb begin
    px_base    = (state == IN_FRAME && !s_axis_tuser) ? px_cnt : '0;
    ln_base    = s_axis_tuser ? '0 : ln_cnt;
    px_inc     = (px_base == ONES) ? px_base : px_base + 1'b1;
    ln_inc     = (ln_base == ONES) ? ln_base : ln_base + 1'b1;
    close_ev   = 1'b0;
    early_ev   = 1'b0;
    late_ev    = 1'b0;
    sof_pos_ev = 1'b0;
    height_ev  = 1'b0;
    if (hs && state == IN_FRAME) begin
      sof_pos_ev = s_axis_tuser && (px_cnt != '0);
      close_ev   = s_axis_tuser && (px_cnt == '0);
      height_ev  = close_ev && (ln_cnt != exp_height);
      early_ev   = s_axis_tlast && (px_inc < exp_width);
      late_ev    = !s_axis_tlast && (px_inc == exp_width);
    end
    err_ev = early_ev | late_ev | sof_pos_ev | height_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px_cnt        <= '0;
      ln_cnt        <= '0;
      meas_width    <= '0;
      meas_height   <= '0;
      frame_cnt     <= '0;
      err_eol_early <= 1'b0;
      err_eol_late  <= 1'b0;
      err_sof_pos   <= 1'b0;
      err_height    <= 1'b0;
      frame_err     <= 1'b0;
      one_clean     <= 1'b0;
      locked        <= 1'b0;
    end else begin
      err_eol_early <= (err_eol_early & ~clr_err) | early_ev;
      err_eol_late  <= (err_eol_late  & ~clr_err) | late_ev;
      err_sof_pos   <= (err_sof_pos   & ~clr_err) | sof_pos_ev;
      err_height    <= (err_height    & ~clr_err) | height_ev;

      if (hs) begin
        if (state == WAIT_SOF) begin
          if (s_axis_tuser) begin
            px_cnt <= s_axis_tlast ? '0 : CNTW'(1);
            ln_cnt <= '0;
          end
        end else begin
          // A misplaced SOF only restarts the measurement; it does not close a frame.
          if (close_ev) begin
            meas_height <= ln_cnt;
            frame_cnt   <= frame_cnt + 1'b1;
          end
          if (s_axis_tlast) begin
            meas_width <= px_inc;
            px_cnt     <= '0;
            ln_cnt     <= ln_inc;
          end else begin
            px_cnt <= px_inc;
            ln_cnt <= ln_base;
          end
        end
      end

      // Errors on the EOL half of a tuser+tlast beat belong to the new frame.
      if (hs && s_axis_tuser) frame_err <= early_ev;
      else                    frame_err <= frame_err | err_ev;

      if (err_ev) begin
        one_clean <= 1'b0;
        locked    <= 1'b0;
      end else if (close_ev) begin
        if (frame_err)      one_clean <= 1'b0;
        else if (one_clean) locked    <= 1'b1;
        else                one_clean <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_axis_monitor.sv
// Randomized bench: line/frame-level geometry model plus a beat scoreboard.
module tb_video_axis_monitor;

  localparam int DATAW = 24;
  localparam int CNTW  = 13;
  localparam int FCW   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [DATAW-1:0] s_axis_tdata;
  logic             s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
  logic [DATAW-1:0] m_axis_tdata;
  logic             m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
  logic [CNTW-1:0]  exp_width, exp_height;
  logic             clr_err;
  logic [CNTW-1:0]  meas_width, meas_height;
  logic [FCW-1:0]   frame_cnt;
  logic             err_eol_early, err_eol_late, err_sof_pos, err_height, locked;

  video_axis_monitor #(.DATAW(DATAW), .CNTW(CNTW), .FCW(FCW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .exp_width(exp_width), .exp_height(exp_height), .clr_err(clr_err),
    .meas_width(meas_width), .meas_height(meas_height), .frame_cnt(frame_cnt),
    .err_eol_early(err_eol_early), .err_eol_late(err_eol_late),
    .err_sof_pos(err_sof_pos), .err_height(err_height), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [DATAW+1:0] exp_q[$];
  bit bp_en = 1'b0;

  // Geometry model, per line
  int exp_w = 8, exp_h = 4;
  int started, lines, mw, mh, fc, e_early, e_late, e_sof, e_ht, clean, lk, dirty;

  function automatic void model_reset();
    started = 0; lines = 0; mw = 0; mh = 0; fc = 0;
    e_early = 0; e_late = 0; e_sof = 0; e_ht = 0; clean = 0; lk = 0; dirty = 0;
  endfunction

  function automatic void ev_err();
    clean = 0; lk = 0; dirty = 1;
  endfunction

  // u_at: beat index carrying tuser (-1 none), last: line ends with tlast
  function automatic void model_line(input int len, input int u_at, input bit last);
    int seg;
    seg = len;
    if (u_at == 0) begin
      if (started != 0) begin
        mh = lines;
        fc = (fc + 1) % 65536;
        if (lines != exp_h) begin e_ht = 1; ev_err(); end
        else if (dirty == 0) begin clean++; if (clean >= 2) lk = 1; end
        else clean = 0;
      end
      started = 1; lines = 0; dirty = 0;
    end else if (u_at > 0) begin
      if (started != 0) begin e_sof = 1; ev_err(); end
      started = 1; lines = 0; dirty = 0; seg = len - u_at;
    end
    if (started == 0) return;
    if (seg > exp_w || (!last && seg == exp_w)) begin e_late = 1; ev_err(); end
    if (last) begin
      mw = seg;
      lines++;
      if (seg < exp_w) begin e_early = 1; ev_err(); end
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".meas_width"},  32'(meas_width),  mw);
    chk({tag, ".meas_height"}, 32'(meas_height), mh);
    chk({tag, ".frame_cnt"},   32'(frame_cnt),   fc);
    chk({tag, ".err_early"},   32'(err_eol_early), e_early);
    chk({tag, ".err_late"},    32'(err_eol_late),  e_late);
    chk({tag, ".err_sof"},     32'(err_sof_pos),   e_sof);
    chk({tag, ".err_height"},  32'(err_height),    e_ht);
    chk({tag, ".locked"},      32'(locked),        lk);
  endtask

  task automatic send_beat(input logic [DATAW-1:0] d, input logic u, input logic l);
    int n;
    bit hs;
    n = 0; hs = 1'b0;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    while (!hs) begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk); #1;
      if (!hs) begin
        n++;
        if (n > 200) begin
          chk("s_ready_timeout", 32'(s_axis_tready), 1);
          break;
        end
      end
    end
    if (hs) exp_q.push_back({u, l, d});
    s_axis_tvalid = 1'b0;
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
  endtask

  task automatic send_line(input int len, input int u_at, input bit last);
    for (int i = 0; i < len; i++)
      send_beat(DATAW'($urandom), (i == u_at), last && (i == len - 1));
    model_line(len, u_at, last);
  endtask

  task automatic send_frame(input string tag);
    for (int l = 0; l < exp_h; l++) begin
      send_line(exp_w, (l == 0) ? 0 : -1, 1'b1);
      check_all(tag);
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    e_early = 0; e_late = 0; e_sof = 0; e_ht = 0;
  endtask

  // Downstream ready driver; also confirms s_axis_tready ignores m_axis_tready.
  initial begin
    logic r0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      r0 = s_axis_tready;
      m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bp_en) chk("s_ready_comb", 32'(s_axis_tready), 32'(r0));
    end
  end

  // Output scoreboard and hold-stability monitor
  initial begin
    bit held;
    logic [DATAW+1:0] held_pl, pl;
    held = 1'b0; held_pl = '0;
    forever begin
      @(negedge clk);
      pl = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (rst) held = 1'b0;
      else begin
        if (held) begin
          chk("hold_valid", 32'(m_axis_tvalid), 1);
          chk("hold_data", 32'(pl), 32'(held_pl));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) chk("out_extra", 32'(pl), 32'hdead);
          else chk("out_beat", 32'(pl), 32'(exp_q.pop_front()));
        end
        held = m_axis_tvalid && !m_axis_tready;
        held_pl = pl;
      end
    end
  end

  initial begin
    rst = 1'b1; clr_err = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    exp_width = CNTW'(exp_w); exp_height = CNTW'(exp_h);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.s_ready", 32'(s_axis_tready), 1);
    chk("rst.m_valid", 32'(m_axis_tvalid), 0);
    check_all("rst");

    // Nominal 8x4 frames
    send_frame("nom1");
    send_frame("nom2");
    send_line(exp_w, 0, 1'b1);
    chk("nom.fc_third_sof", 32'(frame_cnt), 2);
    chk("nom.locked", 32'(locked), 1);
    for (int l = 1; l < exp_h; l++) send_line(exp_w, -1, 1'b1);
    check_all("nom3");

    // Random downstream backpressure
    bp_en = 1'b1;
    send_frame("bp1");
    send_frame("bp2");
    bp_en = 1'b0;

    // Short line
    send_line(exp_w, 0, 1'b1);
    send_line(exp_w, -1, 1'b1);
    send_line(6, -1, 1'b1);
    check_all("short");
    chk("short.early", 32'(err_eol_early), 1);
    chk("short.width", 32'(meas_width), 6);
    chk("short.locked", 32'(locked), 0);
    pulse_clr();
    check_all("clr");
    send_line(exp_w, -1, 1'b1);

    // Long line: late flag must rise exactly on beat 8
    send_line(exp_w, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      send_beat(DATAW'($urandom), 1'b0, (i == 9));
      if (i == 6) chk("long.late_b7", 32'(err_eol_late), 0);
      if (i == 7) chk("long.late_b8", 32'(err_eol_late), 1);
    end
    model_line(10, -1, 1'b1);
    check_all("long");
    chk("long.width", 32'(meas_width), 10);
    send_line(exp_w, -1, 1'b1);
    send_line(exp_w, -1, 1'b1);

    // Misplaced SOF, then a 5-line frame
    send_line(exp_w, 0, 1'b1);
    send_line(11, 3, 1'b1);
    check_all("sofpos");
    chk("sofpos.flag", 32'(err_sof_pos), 1);
    for (int l = 0; l < 4; l++) send_line(exp_w, -1, 1'b1);
    send_line(exp_w, 0, 1'b1);
    check_all("height");
    chk("height.flag", 32'(err_height), 1);
    chk("height.meas", 32'(meas_height), 5);

    // Reset in the middle of line 2
    send_line(exp_w, -1, 1'b1);
    send_line(5, -1, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk("mrst.s_ready", 32'(s_axis_tready), 1);
    chk("mrst.m_valid", 32'(m_axis_tvalid), 0);
    check_all("mrst");
    send_frame("post1");
    chk("post.fc", 32'(frame_cnt), 0);
    send_frame("post2");
    send_frame("post3");
    send_line(exp_w, 0, 1'b1);
    check_all("post4");

    // Drain the pipeline
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    #1 chk("drain.left", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
